// File: rtl/commit_store_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : commit_store_queue_pkg
//  Description : Shared types for the ROB retirement / store queue block.
//  Revision    : 1.0  initial release
// ============================================================================
package commit_store_queue_pkg;

    // Lifecycle of a reorder-buffer entry; only S_EXECUTED entries may retire.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUED   = 2'd1,
        S_EXECUTED = 2'd2,
        S_SPARE    = 2'd3
    } e_state_t;

    // Access width of a memory operation.
    typedef enum logic [1:0] {
        LDST_BYTE  = 2'd0,
        LDST_HALF  = 2'd1,
        LDST_WORD  = 2'd2,
        LDST_RSVD  = 2'd3
    } ldst_mode_t;

    // One reorder-buffer entry as presented to the retirement logic.
    typedef struct packed {
        e_state_t    e_state;  // execution state
        logic        is_st;    // entry is a store
        logic [4:0]  Dest;     // destination register
        logic [31:0] result;   // result written to the register file
        ldst_mode_t  rwmm;     // store access width
        logic [31:0] A;        // store address
        logic [31:0] Vk;       // store data
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/commit_store_queue.sv
`default_nettype none
// ============================================================================
//  Module      : commit_store_queue
//  Description : N-wide in-order ROB retirement with a registered store queue
//                draining to data memory over valid/ready, plus load/store
//                word-address overlap detection.
//  Revision    : 1.0  initial release
// ============================================================================
module commit_store_queue
    import commit_store_queue_pkg::*;
#(
    parameter int BUF_SIZE     = 16,
    parameter int COMMIT_WIDTH = 4,
    parameter int MAX_STORES   = 2,
    parameter int SQ_DEPTH     = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  entry_t [BUF_SIZE-1:0]                 entries,
    input  logic                                  flush,
    output logic [COMMIT_WIDTH-1:0]               is_valid,
    output logic [COMMIT_WIDTH-1:0][4:0]          reg_addr,
    output logic [COMMIT_WIDTH-1:0][31:0]         reg_data,
    output logic [COMMIT_WIDTH-1:0]               is_store,
    output logic [$clog2(COMMIT_WIDTH+1)-1:0]     commit_count,
    output logic                                  mem_req_valid,
    output ldst_mode_t                            mem_req_mode,
    output logic [31:0]                           mem_req_addr,
    output logic [31:0]                           mem_req_data,
    input  logic                                  mem_req_ready,
    input  logic [31:0]                           load_addr,
    output logic                                  load_conflict,
    output logic [$clog2(SQ_DEPTH+1)-1:0]         sq_count,
    output logic                                  sq_empty
);

    localparam int SCW = $clog2(SQ_DEPTH + 1);
    localparam int CCW = $clog2(COMMIT_WIDTH + 1);
    localparam int PW  = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;

    // Queue state
    logic [PW-1:0]        head_q;
    logic [PW-1:0]        tail_q;
    logic [SCW-1:0]       count_q;
    logic [SQ_DEPTH-1:0]  valid_q;
    ldst_mode_t           mode_q [SQ_DEPTH];
    logic [31:0]          addr_q [SQ_DEPTH];
    logic [31:0]          data_q [SQ_DEPTH];

    // Retirement decode results
    logic [SCW-1:0]                  free_w;
    logic [SCW-1:0]                  n_st_w;
    logic [COMMIT_WIDTH-1:0][PW-1:0] enq_idx_w;
    logic                            ok_w;
    logic                            blocked_w;
    logic                            deq_w;

    // Walk the head slots in age order; the first slot that cannot retire
    // (not executed, or a store beyond either store limit) stops all younger ones.
    // Free space is taken from the registered count only, so a dequeue this
    // cycle never makes room for a store retiring in the same cycle.
    always_comb begin
        is_valid     = '0;
        is_store     = '0;
        reg_addr     = '0;
        reg_data     = '0;
        commit_count = '0;
        n_st_w       = '0;
        enq_idx_w    = '0;
        blocked_w    = 1'b0;
        ok_w         = 1'b0;
        free_w       = SCW'(SQ_DEPTH) - count_q;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            ok_w = !blocked_w && !flush && !reset && (entries[i].e_state == S_EXECUTED);
            if (entries[i].is_st && ((n_st_w >= SCW'(MAX_STORES)) || (n_st_w >= free_w))) begin
                ok_w = 1'b0;
            end
            if (ok_w) begin
                is_valid[i]  = 1'b1;
                reg_addr[i]  = entries[i].Dest;
                reg_data[i]  = entries[i].result;
                commit_count = commit_count + CCW'(1);
                if (entries[i].is_st) begin
                    is_store[i]  = 1'b1;
                    enq_idx_w[i] = tail_q + PW'(n_st_w);
                    n_st_w       = n_st_w + SCW'(1);
                end
            end else begin
                blocked_w = 1'b1;
            end
        end
    end

    assign mem_req_valid = (count_q != '0);
    assign deq_w         = mem_req_valid && mem_req_ready;
    assign mem_req_mode  = mem_req_valid ? mode_q[head_q] : LDST_WORD;
    assign mem_req_addr  = mem_req_valid ? addr_q[head_q] : 32'd0;
    assign mem_req_data  = mem_req_valid ? data_q[head_q] : 32'd0;
    assign sq_count      = count_q;
    assign sq_empty      = (count_q == '0);

    // Pointer, occupancy and per-entry valid tracking; reset discards pending stores.
    // An enqueue never targets the slot being dequeued, since it only fills free slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (deq_w) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (is_store[i]) begin
                    valid_q[enq_idx_w[i]] <= 1'b1;
                end
            end
            tail_q  <= tail_q + PW'(n_st_w);
            count_q <= count_q + n_st_w - SCW'(deq_w);
        end
    end

    // Store payload capture; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (is_store[i]) begin
                mode_q[enq_idx_w[i]] <= entries[i].rwmm;
                addr_q[enq_idx_w[i]] <= entries[i].A;
                data_q[enq_idx_w[i]] <= entries[i].Vk;
            end
        end
    end

    // Word-granular overlap between the issuing load and any queued store.
    always_comb begin
        load_conflict = 1'b0;
        for (int j = 0; j < SQ_DEPTH; j++) begin
            if (valid_q[j] && (addr_q[j][31:2] == load_addr[31:2])) begin
                load_conflict = 1'b1;
            end
        end
    end

    // ROB slots beyond the retire window and the byte offset of the load are not examined.
    generate
        if (BUF_SIZE > COMMIT_WIDTH) begin : g_unused_slots
            logic unused_w;
            assign unused_w = ^{entries[BUF_SIZE-1:COMMIT_WIDTH], load_addr[1:0]};
        end else begin : g_unused_off
            logic unused_w;
            assign unused_w = ^load_addr[1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_commit_store_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_commit_store_queue
//  Description : Self-checking bench for commit_store_queue with a scoreboard
//                of expected memory requests.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_commit_store_queue;
    import commit_store_queue_pkg::*;

    typedef struct {
        ldst_mode_t  mode;
        logic [31:0] addr;
        logic [31:0] data;
    } sb_item_t;

    logic              clk = 1'b0;
    logic              reset;
    entry_t [15:0]     entries;
    logic              flush;
    logic [3:0]        is_valid;
    logic [3:0][4:0]   reg_addr;
    logic [3:0][31:0]  reg_data;
    logic [3:0]        is_store;
    logic [2:0]        commit_count;
    logic              mem_req_valid;
    ldst_mode_t        mem_req_mode;
    logic [31:0]       mem_req_addr;
    logic [31:0]       mem_req_data;
    logic              mem_req_ready;
    logic [31:0]       load_addr;
    logic              load_conflict;
    logic [2:0]        sq_count;
    logic              sq_empty;

    int n_vec  = 0;
    int n_miss = 0;
    sb_item_t sb[$];

    commit_store_queue dut (
        .clk           (clk),
        .reset         (reset),
        .entries       (entries),
        .flush         (flush),
        .is_valid      (is_valid),
        .reg_addr      (reg_addr),
        .reg_data      (reg_data),
        .is_store      (is_store),
        .commit_count  (commit_count),
        .mem_req_valid (mem_req_valid),
        .mem_req_mode  (mem_req_mode),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_ready (mem_req_ready),
        .load_addr     (load_addr),
        .load_conflict (load_conflict),
        .sq_count      (sq_count),
        .sq_empty      (sq_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t mk(e_state_t st, logic s, logic [4:0] d, logic [31:0] r,
                                  ldst_mode_t m, logic [31:0] a, logic [31:0] v);
        entry_t e;
        e.e_state = st;
        e.is_st   = s;
        e.Dest    = d;
        e.result  = r;
        e.rwmm    = m;
        e.A       = a;
        e.Vk      = v;
        return e;
    endfunction

    task automatic clear_entries();
        for (int i = 0; i < 16; i++) entries[i] = mk(S_IDLE, 1'b0, 5'd0, 32'd0, LDST_WORD, 32'd0, 32'd0);
    endtask

    task automatic push_exp(input ldst_mode_t m, input logic [31:0] a, input logic [31:0] d);
        sb_item_t it;
        it.mode = m;
        it.addr = a;
        it.data = d;
        sb.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Memory-side monitor: every accepted request must match the oldest expected store.
    initial begin
        sb_item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (mem_req_valid && mem_req_ready && !reset) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    it = sb.pop_front();
                    chk("mem_mode", 32'(mem_req_mode), 32'(it.mode));
                    chk("mem_addr", mem_req_addr, it.addr);
                    chk("mem_data", mem_req_data, it.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        mem_req_ready = 1'b0;
        load_addr = 32'd0;
        clear_entries();

        // Reset suppresses retirement even with executed entries
        @(negedge clk);
        for (int i = 0; i < 4; i++) entries[i] = mk(S_EXECUTED, 1'b0, 5'(i + 1), 32'hA0 + 32'(i), LDST_WORD, 32'd0, 32'd0);
        #1;
        chk("rst_cc", 32'(commit_count), 32'd0);
        chk("rst_valid", 32'(is_valid), 32'd0);
        step();
        reset = 1'b0;
        clear_entries();
        #1;
        chk("rst_empty", 32'(sq_empty), 32'd1);
        chk("rst_mvalid", 32'(mem_req_valid), 32'd0);
        chk("rst_cnt", 32'(sq_count), 32'd0);
        chk("rst_conf", 32'(load_conflict), 32'd0);
        chk("rst_mode", 32'(mem_req_mode), 32'(LDST_WORD));
        chk("rst_addr", mem_req_addr, 32'd0);

        // Four executed ALU ops retire together
        step();
        for (int i = 0; i < 4; i++) entries[i] = mk(S_EXECUTED, 1'b0, 5'(i + 1), 32'hA0 + 32'(i), LDST_WORD, 32'd0, 32'd0);
        #1;
        chk("t1_valid", 32'(is_valid), 32'hF);
        chk("t1_cc", 32'(commit_count), 32'd4);
        chk("t1_store", 32'(is_store), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_raddr", 32'(reg_addr[i]), 32'(i + 1));
            chk("t1_rdata", reg_data[i], 32'hA0 + 32'(i));
        end

        // Non-executed slot 1 blocks everything younger; invalid slot outputs are zero
        step();
        entries[1].e_state = S_ISSUED;
        #1;
        chk("t2_valid", 32'(is_valid), 32'h1);
        chk("t2_cc", 32'(commit_count), 32'd1);
        chk("t2_raddr1", 32'(reg_addr[1]), 32'd0);
        chk("t2_rdata3", reg_data[3], 32'd0);

        // Three stores, empty queue: store limit admits two
        step();
        clear_entries();
        for (int i = 0; i < 3; i++) entries[i] = mk(S_EXECUTED, 1'b1, 5'd0, 32'd0, LDST_WORD, 32'h100 + 32'(4 * i), 32'hD0 + 32'(i));
        #1;
        chk("t3_valid", 32'(is_valid), 32'h3);
        chk("t3_store", 32'(is_store), 32'h3);
        chk("t3_cc", 32'(commit_count), 32'd2);
        push_exp(LDST_WORD, 32'h100, 32'hD0);
        push_exp(LDST_WORD, 32'h104, 32'hD1);
        step();
        clear_entries();
        #1;
        chk("t3_cnt", 32'(sq_count), 32'd2);
        chk("t3_mvalid", 32'(mem_req_valid), 32'd1);
        chk("t3_head", mem_req_addr, 32'h100);

        // Fill to three, then two stores with one free slot and a same-cycle dequeue
        step();
        entries[0] = mk(S_EXECUTED, 1'b1, 5'd0, 32'd0, LDST_BYTE, 32'h10C, 32'hD3);
        push_exp(LDST_BYTE, 32'h10C, 32'hD3);
        step();
        entries[0] = mk(S_EXECUTED, 1'b1, 5'd0, 32'd0, LDST_WORD, 32'h110, 32'hD4);
        entries[1] = mk(S_EXECUTED, 1'b1, 5'd0, 32'd0, LDST_WORD, 32'h114, 32'hD5);
        mem_req_ready = 1'b1;
        #1;
        chk("t4_cnt3", 32'(sq_count), 32'd3);
        chk("t4_valid", 32'(is_valid), 32'h1);
        chk("t4_cc", 32'(commit_count), 32'd1);
        push_exp(LDST_WORD, 32'h110, 32'hD4);
        step();
        clear_entries();
        mem_req_ready = 1'b0;
        #1;
        chk("t4_cnt_hold", 32'(sq_count), 32'd3);

        // Drain the queue completely
        mem_req_ready = 1'b1;
        for (int k = 0; k < 20 && !sq_empty; k++) step();
        mem_req_ready = 1'b0;
        chk("drain_empty", 32'(sq_empty), 32'd1);

        // Stalled head store: stable outputs and word-granular conflict
        entries[0] = mk(S_EXECUTED, 1'b1, 5'd0, 32'd0, LDST_HALF, 32'h1004, 32'hDEAD);
        load_addr = 32'h1004;
        #1;
        chk("t5_enq_invis", 32'(load_conflict), 32'd0);
        push_exp(LDST_HALF, 32'h1004, 32'hDEAD);
        for (int c = 0; c < 3; c++) begin
            step();
            clear_entries();
            load_addr = (c == 1) ? 32'h1008 : 32'h1006;
            #1;
            chk("t5_mvalid", 32'(mem_req_valid), 32'd1);
            chk("t5_addr", mem_req_addr, 32'h1004);
            chk("t5_data", mem_req_data, 32'hDEAD);
            chk("t5_mode", 32'(mem_req_mode), 32'(LDST_HALF));
            chk("t5_conf", 32'(load_conflict), (c == 1) ? 32'd0 : 32'd1);
        end
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        load_addr = 32'h1004;
        #1;
        chk("t5_empty", 32'(sq_empty), 32'd1);
        chk("t5_conf_gone", 32'(load_conflict), 32'd0);

        // Flush blocks retirement while the queue keeps draining; reset drops the rest
        step();
        entries[0] = mk(S_EXECUTED, 1'b1, 5'd0, 32'd0, LDST_WORD, 32'h2000, 32'hE0);
        entries[1] = mk(S_EXECUTED, 1'b1, 5'd0, 32'd0, LDST_WORD, 32'h2004, 32'hE1);
        push_exp(LDST_WORD, 32'h2000, 32'hE0);
        push_exp(LDST_WORD, 32'h2004, 32'hE1);
        step();
        for (int i = 0; i < 4; i++) entries[i] = mk(S_EXECUTED, 1'b0, 5'(i + 8), 32'h55, LDST_WORD, 32'd0, 32'd0);
        flush = 1'b1;
        mem_req_ready = 1'b1;
        #1;
        chk("t6_cc", 32'(commit_count), 32'd0);
        chk("t6_valid", 32'(is_valid), 32'd0);
        chk("t6_cnt", 32'(sq_count), 32'd2);
        step();
        mem_req_ready = 1'b0;
        #1;
        chk("t6_drained1", 32'(sq_count), 32'd1);
        reset = 1'b1;
        sb.delete();
        step();
        reset = 1'b0;
        flush = 1'b0;
        clear_entries();
        #1;
        chk("t6_empty", 32'(sq_empty), 32'd1);
        chk("t6_mvalid", 32'(mem_req_valid), 32'd0);
        chk("t6_cnt0", 32'(sq_count), 32'd0);
        chk("sb_left", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
